// File: rtl/arb_pkg.sv
// Helpers shared between the round-robin arbiter and its response router:
// index width, one-hot encoding and one-hot validity.
package arb_pkg;

    localparam int MAX_N = 256;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // OR-reduction of set-bit indices; only meaningful for a one-hot input
    function automatic int onehot_to_idx(input logic [MAX_N-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++)
            if (v[i]) idx = idx | i;
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Issue-order tag FIFO. Head comes from registered state only, so an entry
// pushed in cycle t is first visible at t+1.
module arb_tag_fifo #(
    parameter  int W     = 5,
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rr_rsp_router.sv
// Steers in-order resource responses back to the requester whose grant was
// accepted, using a FIFO of grant indices recorded at issue time.
module rr_rsp_router
    import arb_pkg::*;
#(
    parameter  int N      = 32,
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 32,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      gnt_i,
    input  logic              gnt_accept_i,
    output logic              issue_stall_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              rsp_ready_o,
    output logic [N-1:0]      cli_rsp_valid_o,
    output logic [DATA_W-1:0] cli_rsp_data_o,
    input  logic [N-1:0]      cli_rsp_ready_i,
    output logic [CW-1:0]     outstanding_o,
    output logic              err_onehot_o,
    output logic              err_underflow_o
);
    localparam int IW = idx_w(N);

    logic [1:0]          rst_sync;
    logic                arst_n;
    logic [MAX_N-1:0]    gnt_ext;
    logic                gnt_ok, push, pop, full, empty;
    logic [IW-1:0]       push_idx, head_idx;
    logic                slot_valid, slot_drain;
    logic [IW-1:0]       slot_idx;
    logic [DATA_W-1:0]   slot_data;

    // Reset asserts asynchronously, releases two edges after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign arst_n = rst_sync[1];

    always_comb begin
        gnt_ext        = '0;
        gnt_ext[N-1:0] = gnt_i;
    end

    assign gnt_ok   = is_onehot(gnt_ext);
    assign push_idx = IW'(onehot_to_idx(gnt_ext));
    assign push     = gnt_accept_i & gnt_ok & ~full;

    assign slot_drain  = slot_valid & cli_rsp_ready_i[slot_idx];
    assign rsp_ready_o = ~empty & (~slot_valid | slot_drain);
    assign pop         = rsp_valid_i & rsp_ready_o;

    arb_tag_fifo #(.W(IW), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (arst_n),
        .push  (push),
        .wdata (push_idx),
        .pop   (pop),
        .rdata (head_idx),
        .full  (full),
        .empty (empty),
        .count (outstanding_o)
    );

    assign issue_stall_o = full;

    // Load wins over drain so a same-cycle drain+load keeps the slot full
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            slot_valid <= 1'b0;
            slot_idx   <= '0;
            slot_data  <= '0;
        end else if (pop) begin
            slot_valid <= 1'b1;
            slot_idx   <= head_idx;
            slot_data  <= rsp_data_i;
        end else if (slot_drain) begin
            slot_valid <= 1'b0;
        end
    end

    always_comb begin
        cli_rsp_valid_o = '0;
        if (slot_valid) cli_rsp_valid_o[slot_idx] = 1'b1;
    end
    assign cli_rsp_data_o = slot_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_onehot_o    <= 1'b0;
            err_underflow_o <= 1'b0;
        end else begin
            if (gnt_accept_i & ~gnt_ok) err_onehot_o    <= 1'b1;
            if (rsp_valid_i & empty)    err_underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_rsp_router.sv
// Directed bench for rr_rsp_router: a tag/response model feeds a scoreboard
// that a negedge monitor pops whenever a client response drains.
module tb_rr_rsp_router;
    localparam int N = 32, DEPTH = 8, DATA_W = 32, CW = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      gnt_i;
    logic              gnt_accept_i;
    logic              issue_stall_o;
    logic              rsp_valid_i;
    logic [DATA_W-1:0] rsp_data_i;
    logic              rsp_ready_o;
    logic [N-1:0]      cli_rsp_valid_o;
    logic [DATA_W-1:0] cli_rsp_data_o;
    logic [N-1:0]      cli_rsp_ready_i;
    logic [CW-1:0]     outstanding_o;
    logic              err_onehot_o;
    logic              err_underflow_o;

    rr_rsp_router #(.N(N), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gnt_i           (gnt_i),
        .gnt_accept_i    (gnt_accept_i),
        .issue_stall_o   (issue_stall_o),
        .rsp_valid_i     (rsp_valid_i),
        .rsp_data_i      (rsp_data_i),
        .rsp_ready_o     (rsp_ready_o),
        .cli_rsp_valid_o (cli_rsp_valid_o),
        .cli_rsp_data_o  (cli_rsp_data_o),
        .cli_rsp_ready_i (cli_rsp_ready_i),
        .outstanding_o   (outstanding_o),
        .err_onehot_o    (err_onehot_o),
        .err_underflow_o (err_underflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t expq[$];
    int   tagq[$];
    int   mcount   = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   drains   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model-side acceptance decision; the DUT's stall is checked against it
    task automatic accept(input logic [N-1:0] g);
        gnt_i        = g;
        gnt_accept_i = 1'b1;
        @(negedge clk);
        chk("issue_stall", 64'(issue_stall_o), 64'(mcount == DEPTH));
        if ($countones(g) == 1 && mcount < DEPTH) begin
            tagq.push_back($clog2(g));
            mcount++;
        end
        @(posedge clk); #1;
        gnt_accept_i = 1'b0;
        gnt_i        = '0;
    endtask

    task automatic exp_push(input logic [31:0] d);
        exp_t e;
        e.idx  = tagq.pop_front();
        e.data = d;
        expq.push_back(e);
        mcount--;
    endtask

    task automatic send_rsp(input logic [31:0] d);
        bit got;
        got         = 1'b0;
        rsp_valid_i = 1'b1;
        rsp_data_i  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_ready_o === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("rsp_ready_timeout", 64'(rsp_ready_o), 64'(1));
        else      exp_push(d);
        @(posedge clk); #1;
        rsp_valid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},  64'(issue_stall_o),   64'(0));
        chk({tag, "_ready"},  64'(rsp_ready_o),     64'(0));
        chk({tag, "_cvalid"}, 64'(cli_rsp_valid_o), 64'(0));
        chk({tag, "_cdata"},  64'(cli_rsp_data_o),  64'(0));
        chk({tag, "_outst"},  64'(outstanding_o),   64'(0));
        chk({tag, "_eoh"},    64'(err_onehot_o),    64'(0));
        chk({tag, "_eund"},   64'(err_underflow_o), 64'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("cli_valid_atmost1", 64'($countones(cli_rsp_valid_o) <= 1), 64'(1));
            if ((cli_rsp_valid_o & cli_rsp_ready_i) != '0) begin
                exp_t        e;
                logic [31:0] one;
                drains++;
                one = 32'd1;
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", 64'(cli_rsp_valid_o), 64'(0));
                end else begin
                    e = expq.pop_front();
                    chk("rsp_client", 64'(cli_rsp_valid_o), 64'(one << e.idx));
                    chk("rsp_data",   64'(cli_rsp_data_o),  64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        rst_n = 1'b1; gnt_i = '0; gnt_accept_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_data_i = '0; cli_rsp_ready_i = '1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: idle after reset, response with nothing outstanding
        @(negedge clk);
        chk_all_zero("post_reset");
        @(posedge clk); #1 rsp_valid_i = 1'b1; rsp_data_i = 32'hDEAD;
        @(negedge clk);
        chk("underflow_ready", 64'(rsp_ready_o), 64'(0));
        @(posedge clk); #1 rsp_valid_i = 1'b0;
        @(negedge clk);
        chk("err_underflow", 64'(err_underflow_o), 64'(1));
        chk("underflow_outst", 64'(outstanding_o), 64'(0));
        chk("underflow_cvalid", 64'(cli_rsp_valid_o), 64'(0));
        @(posedge clk); #1;

        // 2: two clients, in-order return
        accept(32'h0000_0008);
        accept(32'h8000_0000);
        @(negedge clk); chk("t2_outst2", 64'(outstanding_o), 64'(2));
        @(posedge clk); #1;
        send_rsp(32'hA5);
        @(negedge clk); chk("t2_outst1", 64'(outstanding_o), 64'(1));
        @(posedge clk); #1;
        send_rsp(32'h5A);
        @(negedge clk); chk("t2_outst0", 64'(outstanding_o), 64'(0));
        repeat (3) @(posedge clk);
        #1 chk("t2_sb_empty", 64'(expq.size()), 64'(0));

        // 3: fill, overflow drop, stall release
        for (int i = 0; i < 8; i++) accept(32'd1 << i);
        @(negedge clk);
        chk("t3_stall", 64'(issue_stall_o), 64'(1));
        chk("t3_outst8", 64'(outstanding_o), 64'(8));
        @(posedge clk); #1;
        accept(32'd1 << 9);
        @(negedge clk);
        chk("t3_drop_outst", 64'(outstanding_o), 64'(8));
        chk("t3_drop_eoh", 64'(err_onehot_o), 64'(0));
        @(posedge clk); #1;
        send_rsp(32'h100);
        @(negedge clk);
        chk("t3_stall_clear", 64'(issue_stall_o), 64'(0));
        chk("t3_outst7", 64'(outstanding_o), 64'(7));
        @(posedge clk); #1;
        for (int i = 1; i < 8; i++) send_rsp(32'h100 + 32'(i));
        repeat (3) @(posedge clk);
        #1 chk("t3_sb_empty", 64'(expq.size()), 64'(0));

        // 4: client 3 backpressure, unrelated ready ignored, then back-to-back
        cli_rsp_ready_i = ~32'h8;
        accept(32'd1 << 3);
        accept(32'd1 << 5);
        accept(32'd1 << 3);
        send_rsp(32'hB0);
        rsp_valid_i = 1'b1; rsp_data_i = 32'hB1;
        d0 = drains;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(cli_rsp_valid_o), 64'h8);
            chk("t4_hold_data",  64'(cli_rsp_data_o),  64'hB0);
            chk("t4_hold_ready", 64'(rsp_ready_o),     64'(0));
            @(posedge clk); #1;
        end
        chk("t4_no_drain", 64'(drains - d0), 64'(0));
        cli_rsp_ready_i = '1;
        @(negedge clk); chk("t4_b2b_ready1", 64'(rsp_ready_o), 64'(1));
        exp_push(32'hB1);
        @(posedge clk); #1 rsp_data_i = 32'hB2;
        @(negedge clk); chk("t4_b2b_ready2", 64'(rsp_ready_o), 64'(1));
        exp_push(32'hB2);
        @(posedge clk); #1 rsp_valid_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("t4_b2b_drains", 64'(drains - d0), 64'(3));
        chk("t4_sb_empty", 64'(expq.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;

        // 5: multi-hot accept, then push+pop in the same cycle at count 4
        accept(32'h0000_0006);
        @(negedge clk);
        chk("t5_err_onehot", 64'(err_onehot_o), 64'(1));
        chk("t5_no_push", 64'(outstanding_o), 64'(0));
        @(posedge clk); #1;
        for (int i = 10; i < 14; i++) accept(32'd1 << i);
        gnt_i = 32'd1 << 14; gnt_accept_i = 1'b1;
        rsp_valid_i = 1'b1; rsp_data_i = 32'hC0;
        @(negedge clk);
        chk("t5_pp_ready", 64'(rsp_ready_o), 64'(1));
        exp_push(32'hC0);
        tagq.push_back(14); mcount++;
        @(posedge clk); #1 gnt_accept_i = 1'b0; gnt_i = '0; rsp_valid_i = 1'b0;
        @(negedge clk); chk("t5_pp_outst4", 64'(outstanding_o), 64'(4));
        @(posedge clk); #1;
        for (int i = 1; i < 5; i++) send_rsp(32'hC0 + 32'(i));
        repeat (3) @(posedge clk);
        #1 chk("t5_sb_empty", 64'(expq.size()), 64'(0));

        // 6: asynchronous reset with tags outstanding and the slot occupied
        cli_rsp_ready_i = '0;
        for (int i = 20; i < 24; i++) accept(32'd1 << i);
        send_rsp(32'hE0);
        @(negedge clk);
        chk("t6_outst3", 64'(outstanding_o), 64'(3));
        chk("t6_slot", 64'(cli_rsp_valid_o), 64'(32'd1 << 20));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        expq.delete(); tagq.delete(); mcount = 0;
        cli_rsp_ready_i = '1;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        accept(32'd1 << 2);
        send_rsp(32'hD0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_sb_empty", 64'(expq.size()), 64'(0));
        chk("t6_outst0", 64'(outstanding_o), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
